// File: rtl/freq_meter_if.sv
// Result/handshake bundle for freq_meter: measured input, consumer ack and the result flags.
interface freq_meter_if #(
    parameter int WIDTH = 32
);
    logic             sig_in;
    logic             ack;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             overrun;
    logic             timeout;

    // master: the meter itself; slave: the consumer/stimulus side
    modport master (
        input  sig_in,
        input  ack,
        output period,
        output high_time,
        output valid,
        output overrun,
        output timeout
    );

    modport slave (
        output sig_in,
        output ack,
        input  period,
        input  high_time,
        input  valid,
        input  overrun,
        input  timeout
    );
endinterface

// File: rtl/freq_meter.sv
// Period/high-time meter for a slow async square wave, counted in clk cycles.
// Result visible 3 edges after the sampled sig_in edge; an unacked result blocks new ones and sets overrun.
module freq_meter #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(100_000_000)
) (
    input  logic          clk,
    input  logic          clr,
    freq_meter_if.master  bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TO_LAST = TIMEOUT - ONE;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s2_d;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] hi_cnt;
    logic             hi_seen;
    logic             time_hit;
    logic             new_res;
    logic             hi_capture;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_time_q;
    logic             valid_q;
    logic             overrun_q;
    logic             timeout_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= bus.sig_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign rise = s2 & ~s2_d;
    assign fall = ~s2 & s2_d;

    always_comb begin
        state_nxt  = state;
        new_res    = 1'b0;
        hi_capture = 1'b0;
        cnt_nxt    = cnt;
        // IDLE may enter with cnt already saturated at TIMEOUT after a MEASURE timeout
        if (state == IDLE) begin
            time_hit = !rise && (cnt >= TO_LAST);
        end else begin
            time_hit = !rise && (cnt == TO_LAST);
        end

        if (rise) begin
            cnt_nxt = ONE;
        end else if (time_hit) begin
            cnt_nxt = (state == IDLE) ? '0 : TIMEOUT;
        end else if (cnt < TIMEOUT) begin
            cnt_nxt = cnt + ONE;
        end

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                hi_capture = fall && !hi_seen;
                if (rise) begin
                    new_res = 1'b1;
                end else if (time_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_cnt  <= '0;
            hi_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rise) begin
                hi_seen <= 1'b0;
            end else if (hi_capture) begin
                hi_cnt  <= cnt;
                hi_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (new_res) begin
                // an ack in the same cycle frees the slot for the new result
                if (!valid_q || bus.ack) begin
                    period_q    <= cnt;
                    high_time_q <= hi_seen ? hi_cnt : cnt;
                    valid_q     <= 1'b1;
                    timeout_q   <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.ack) begin
                valid_q <= 1'b0;
            end
            if (time_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_time_q;
    assign bus.valid     = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.timeout   = timeout_q;
endmodule
